dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words of storage, power of two, 4..1024.
REQ-002 Parameter LATENCY, default 2: wait cycles inserted between request accept and response, 0..15.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port req_valid  input  1: requester presents a memory access.
REQ-006 Port req_ready  output  1: responder accepts the request this cycle.
REQ-007 Port req_we  input  1: 1 = store, 0 = load.
REQ-008 Port req_addr  input  32: byte address.
REQ-009 Port req_wdata  input  32: store data, little-endian lanes.
REQ-010 Port req_be  input  4: store byte enables, bit i covers wdata[8i+7:8i].
REQ-011 Port rsp_valid  output  1: response available.
REQ-012 Port rsp_ready  input  1: requester consumes the response this cycle.
REQ-013 Port rsp_rdata  output  32: load data; 0 for stores and errors.
REQ-014 Port rsp_err  output  1: access was misaligned or out of range.

Function
REQ-015 FSM states IDLE, WAIT, RESP; exactly one request outstanding at any time.
REQ-016 req_ready SHALL be 1 only in IDLE, combinationally, independent of req_valid.
REQ-017 Accept = req_valid & req_ready at a rising edge; we, addr, wdata, be captured in internal registers at that edge; inputs ignored afterwards.
REQ-018 IDLE -> WAIT on accept when LATENCY > 0, loading wait counter with LATENCY-1; IDLE -> RESP on accept when LATENCY = 0.
REQ-019 WAIT: counter decrements each cycle; at counter = 0 the next edge commits the access and enters RESP.
REQ-020 rsp_valid SHALL first be high in the cycle after edge N+LATENCY, where N is the accept edge (LATENCY=0: the cycle immediately after accept).
REQ-021 Error = captured addr[1:0] != 0, or word index addr[31:2] >= DEPTH; on error no storage update, rsp_rdata = 0, rsp_err = 1.
REQ-022 Store commit: only lanes with be bit set are written at the commit edge; be = 4'b0000 is a legal no-op with rsp_err = 0.
REQ-023 Load commit: full 32-bit word registered into rsp_rdata at the commit edge; be ignored for loads.
REQ-024 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready = 1; at that edge -> IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-025 No accept in the cycle a response is consumed; minimum request spacing is LATENCY+2 cycles.
REQ-026 rsp_ready while rsp_valid = 0 has no effect.
REQ-027 Load after store to the same word returns the merged stored data.

Reset
REQ-028 rst asserted: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, capture registers = 0, immediately without waiting for clk.
REQ-029 Reset in WAIT aborts the access: no storage write occurs; reset in RESP drops the pending response.
REQ-030 Storage contents are not reset; bench initialises via stores.

Structure
REQ-031 Shared package pipeline_pkg holds the state enumeration, word width 32, and default DEPTH/LATENCY constants.
REQ-032 One sub-module dmem_array: DEPTH x 4 byte-lane register array with per-lane write enable and synchronous read port.

Verification
REQ-033 LATENCY=2: store addr 0x10 data 0xDEADBEEF be 4'hF, then load 0x10 -> rsp_valid 3 cycles after each accept, load rdata 0xDEADBEEF, err 0.
REQ-034 Byte merge: store 0x11223344 be 4'hF at 0x20, store 0xAABBCCDD be 4'b0101 -> load 0x20 returns 0x11BB33DD.
REQ-035 Errors: load 0x22 and load 4*DEPTH -> rsp_err 1, rdata 0; prior word at 0x20 unchanged.
REQ-036 Backpressure: hold rsp_ready 0 for 5 cycles -> rsp_valid/rdata stable, req_ready 0 throughout; new req_valid not accepted until cycle after consume.
REQ-037 Reset mid-WAIT during store 0xCAFEF00D to 0x30 (old 0x01234567) -> outputs zero asynchronously, later load 0x30 returns 0x01234567.
REQ-038 LATENCY=0 back-to-back loads with rsp_ready tied 1 -> one response every 2 cycles, correct data each.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the data-memory responder
package pipeline_pkg;

  localparam int WORD_W      = 32;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misaligned byte address or word index beyond the storage is an error.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-lane word storage with a registered read port
module dmem_array
  import pipeline_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        wr_be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_clr,
  output logic [WORD_W-1:0] rdata
);

  logic [3:0][7:0]   mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  // Per-lane writes; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_be[l]) mem_q[idx][l] <= wdata[8*l +: 8];
    end
  end

  // Read register: cleared when the response is consumed, loaded on a load commit.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr)     rdata_d = '0;
    else if (rd_en) rdata_d = mem_q[idx];
  end

  // Read register state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding memory responder with fixed wait latency
module dmem_responder
  import pipeline_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept, consume, commit;
  logic              c_we, c_err;
  logic [31:0]       c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic [3:0]        c_be;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign consume   = (state_q == ST_RESP) & rsp_ready;

  // With no wait cycles the access commits on the accept edge, so it must use the live request.
  assign commit  = ZERO_LAT ? accept    : ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign c_we    = ZERO_LAT ? req_we    : we_q;
  assign c_addr  = ZERO_LAT ? req_addr  : addr_q;
  assign c_wdata = ZERO_LAT ? req_wdata : wdata_q;
  assign c_be    = ZERO_LAT ? req_be    : be_q;
  assign c_err   = addr_err(c_addr, DEPTH);

  // Next-state, capture and response-flag logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (ZERO_LAT) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = c_err;
    end
  end

  // State, capture and registered-output flops; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_be  ((commit && c_we && !c_err && !rst) ? c_be : 4'b0000),
    .idx    (c_addr[AW+1:2]),
    .wdata  (c_wdata),
    .rd_en  (commit && !c_we && !c_err),
    .rd_clr (consume),
    .rdata  (rsp_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; consumes the response immediately.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_be = 4'h0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("consume_clears_valid", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err",   32'(rsp_err),   32'd0);
    chk("rst_rdata", rsp_rdata,      32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Full-word store then load.
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("st_lat", 32'(lat), 32'd2);
    chk("st_err", 32'(er), 32'd0);
    chk("st_rdata", rd, 32'd0);
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("ld_lat", 32'(lat), 32'd2);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", 32'(er), 32'd0);

    // Byte-lane merge.
    access(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("merge_rdata", rd, 32'h11BB33DD);

    // be=0 store is a legal no-op.
    access(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("be0_err", 32'(er), 32'd0);
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("be0_unchanged", rd, 32'h11BB33DD);

    // Misaligned and out-of-range accesses.
    access(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    access(1'b0, 32'h100, 32'h0, 4'h0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    access(1'b1, 32'h100, 32'h55555555, 4'hF, rd, er, lat);
    chk("oor_st_err", 32'(er), 32'd1);
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("err_no_update", rd, 32'h11BB33DD);

    // Last valid word.
    access(1'b1, 32'hFC, 32'h5A5AA5A5, 4'hF, rd, er, lat);
    chk("last_st_err", 32'(er), 32'd0);
    access(1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat);
    chk("last_ld", rd, 32'h5A5AA5A5);

    // Backpressure with a second request already waiting.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h20;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_consumed", 32'(rsp_valid), 32'd0);
    chk("bp_rdata_clr", rsp_rdata, 32'd0);
    chk("bp_idle_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_lat", 32'(lat), 32'd2);
    chk("bp2_rdata", rsp_rdata, 32'h11BB33DD);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset mid-WAIT aborts the store.
    access(1'b1, 32'h30, 32'h01234567, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_in_wait", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rw_async_ready", 32'(req_ready), 32'd1);
    chk("rw_async_valid", 32'(rsp_valid), 32'd0);
    chk("rw_async_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    access(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("rw_old_kept", rd, 32'h01234567);

    // Reset in RESP drops the pending response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rr_pending", rsp_rdata, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    chk("rr_async_valid", 32'(rsp_valid), 32'd0);
    chk("rr_async_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rr_stays_idle", 32'(rsp_valid), 32'd0);

    // LATENCY=0: back-to-back stores then loads, rsp_ready tied high.
    @(negedge clk);
    z_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      z_req_we    = (k < 4);
      z_req_addr  = 32'((k % 4) * 4);
      z_req_wdata = 32'hA0B0C0D0 + 32'(k % 4);
      z_req_be    = 4'hF;
      @(posedge clk); #1;
      chk("z_valid", 32'(z_rsp_valid), 32'd1);
      chk("z_err", 32'(z_rsp_err), 32'd0);
      chk("z_rdata", z_rsp_rdata, (k < 4) ? 32'd0 : 32'hA0B0C0D0 + 32'(k % 4));
      @(posedge clk); #1;
      chk("z_gap_valid", 32'(z_rsp_valid), 32'd0);
      chk("z_gap_ready", 32'(z_req_ready), 32'd1);
    end
    z_req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
